write_back_stage: RTL and testbench

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

---
 rtl/cpu_core_params.sv | 28 ++
 rtl/load_aligner.sv | 57 +++++
 rtl/write_back_stage.sv | 67 ++++++
 tb/tb_write_back_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_params.sv
// Shared types for the CPU core pipeline: load opcodes, the memory-to-writeback
// stage bundle and the writeback bypass record seen by decode.
package cpu_core_params;

  typedef enum logic [2:0] {
    NONE, LB, LBU, LH, LHU, LW, LWL, LWR
  } load_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        reg_write;
    logic [4:0]  dest;
    load_op_t    load_op;
    logic [1:0]  addr_low;
    logic [31:0] alu_result;
  } mem_to_wb_t;

  // partial marks an LWL/LWR merge that decode cannot bypass and must stall on.
  typedef struct packed {
    logic        valid;
    logic        partial;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_forward_t;

  localparam logic [3:0] STRB_FULL = 4'b1111;

endpackage

// File: rtl/load_aligner.sv
// Combinational load alignment: picks and extends the addressed byte/halfword,
// or shifts data for the unaligned LWL/LWR merge and reports the byte strobe.
module load_aligner
  import cpu_core_params::*;
(
  input  load_op_t    load_op,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  input  logic [31:0] alu_result,
  output logic [31:0] data,
  output logic [3:0]  strobe
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [4:0]  lwl_shift;
  logic [4:0]  lwr_shift;

  always_comb begin
    byte_val = rdata[7:0];
    case (addr_low)
      2'd0: byte_val = rdata[7:0];
      2'd1: byte_val = rdata[15:8];
      2'd2: byte_val = rdata[23:16];
      2'd3: byte_val = rdata[31:24];
      default: byte_val = rdata[7:0];
    endcase
  end

  // addr_low[0] is ignored for halfwords; misalignment traps upstream.
  assign half_val  = addr_low[1] ? rdata[31:16] : rdata[15:0];
  assign lwl_shift = {2'd3 - addr_low, 3'b000};
  assign lwr_shift = {addr_low, 3'b000};

  always_comb begin
    data   = alu_result;
    strobe = STRB_FULL;
    case (load_op)
      NONE: data = alu_result;
      LB:   data = {{24{byte_val[7]}}, byte_val};
      LBU:  data = {24'd0, byte_val};
      LH:   data = {{16{half_val[15]}}, half_val};
      LHU:  data = {16'd0, half_val};
      LW:   data = rdata;
      LWL: begin
        data   = rdata << lwl_shift;
        strobe = STRB_FULL << (2'd3 - addr_low);
      end
      LWR: begin
        data   = rdata >> lwr_shift;
        strobe = STRB_FULL >> addr_low;
      end
      default: data = alu_result;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// Writeback pipeline stage: holds one retiring instruction, aligns load data,
// drives the register-file write port, the decode bypass and the retire trace.
module write_back_stage
  import cpu_core_params::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mem_valid,
  output logic        wb_allow_in,
  input  mem_to_wb_t  mem_bundle,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  output logic        write_enabled,
  output logic [4:0]  write_address,
  output logic [3:0]  write_strobe,
  output logic [31:0] write_data,
  output wb_forward_t wb_forward,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  // Handshake: an instruction moves from memory to writeback on a rising edge
  // where mem_valid && wb_allow_in; wb_allow_in never depends on mem_valid.
  logic       wb_valid;
  logic       wb_ready_go;
  mem_to_wb_t wb_q;

  assign wb_ready_go = 1'b1;
  assign wb_allow_in = !wb_valid || wb_ready_go;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_q     <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (wb_allow_in) begin
      wb_valid <= mem_valid;
      if (mem_valid) wb_q <= mem_bundle;
    end
  end

  load_aligner u_load_aligner (
    .load_op    (wb_q.load_op),
    .addr_low   (wb_q.addr_low),
    .rdata      (data_sram_rdata),
    .alu_result (wb_q.alu_result),
    .data       (write_data),
    .strobe     (write_strobe)
  );

  assign write_enabled = wb_valid && wb_q.reg_write && !flush;
  assign write_address = wb_q.dest;

  assign wb_forward.valid   = write_enabled;
  assign wb_forward.partial = write_enabled && (write_strobe != STRB_FULL);
  assign wb_forward.dest    = wb_q.dest;
  assign wb_forward.data    = (write_strobe == STRB_FULL) ? write_data : 32'd0;

  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_wen   = write_enabled ? write_strobe : 4'b0000;
  assign debug_wb_rf_wnum  = wb_q.dest;
  assign debug_wb_rf_wdata = write_data;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed self-checking bench for write_back_stage.
module tb_write_back_stage;
  import cpu_core_params::*;

  logic        clock;
  logic        reset_n;
  logic        mem_valid;
  logic        wb_allow_in;
  mem_to_wb_t  mem_bundle;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        write_enabled;
  logic [4:0]  write_address;
  logic [3:0]  write_strobe;
  logic [31:0] write_data;
  wb_forward_t wb_forward;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_cmp = 0;
  int n_err = 0;

  write_back_stage dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .mem_valid         (mem_valid),
    .wb_allow_in       (wb_allow_in),
    .mem_bundle        (mem_bundle),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .write_enabled     (write_enabled),
    .write_address     (write_address),
    .write_strobe      (write_strobe),
    .write_data        (write_data),
    .wb_forward        (wb_forward),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic mem_to_wb_t mk(input logic [31:0] pc, input logic [4:0] dest,
                                    input load_op_t op, input logic [1:0] k,
                                    input logic [31:0] alu);
    mem_to_wb_t b;
    b.pc         = pc;
    b.reg_write  = 1'b1;
    b.dest       = dest;
    b.load_op    = op;
    b.addr_low   = k;
    b.alu_result = alu;
    return b;
  endfunction

  // Present b to the stage and advance to 1 time unit past the capturing edge.
  task automatic issue(input mem_to_wb_t b);
    mem_valid  = 1'b1;
    mem_bundle = b;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; mem_valid = 1'b0; flush = 1'b0;
    mem_bundle = '0; data_sram_rdata = 32'h0;
    repeat (2) @(posedge clock);
    #2;
    mem_valid = 1'b1; mem_bundle = mk(32'h44, 5'd7, NONE, 2'd0, 32'h1);
    @(posedge clock); #2;
    n_cmp++; if (write_enabled !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b want 0", write_enabled); end
    n_cmp++; if (debug_wb_rf_wen !== 4'b0) begin n_err++; $display("FAIL reset_dbg_wen got %h want 0", debug_wb_rf_wen); end
    n_cmp++; if (wb_forward.valid !== 1'b0) begin n_err++; $display("FAIL reset_fwd_valid got %b want 0", wb_forward.valid); end
    n_cmp++; if (wb_allow_in !== 1'b1) begin n_err++; $display("FAIL reset_allow_in got %b want 1", wb_allow_in); end
    n_cmp++; if (debug_wb_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", debug_wb_pc); end
    mem_valid = 1'b0;
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_alu;
    issue(mk(32'h100, 5'd3, NONE, 2'd1, 32'hDEADBEEF));
    mem_valid = 1'b0; #1;
    n_cmp++; if (write_enabled !== 1'b1) begin n_err++; $display("FAIL alu_wen got %b want 1", write_enabled); end
    n_cmp++; if (write_address !== 5'd3) begin n_err++; $display("FAIL alu_addr got %0d want 3", write_address); end
    n_cmp++; if (write_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_data got %h want deadbeef", write_data); end
    n_cmp++; if (write_strobe !== 4'hF) begin n_err++; $display("FAIL alu_strobe got %h want f", write_strobe); end
    n_cmp++; if (wb_forward !== '{1'b1, 1'b0, 5'd3, 32'hDEADBEEF}) begin n_err++; $display("FAIL alu_fwd got %h", wb_forward); end
    n_cmp++; if (debug_wb_pc !== 32'h100) begin n_err++; $display("FAIL alu_pc got %h want 100", debug_wb_pc); end
  endtask

  typedef struct {
    load_op_t    op;
    logic [1:0]  k;
    logic [31:0] rdata;
    logic [31:0] data;
    logic [3:0]  strb;
  } vec_t;

  task automatic test_loads;
    vec_t v[13];
    v[0]  = '{LB,  2'd2, 32'h12F45678, 32'hFFFFFFF4, 4'hF};
    v[1]  = '{LBU, 2'd2, 32'h12F45678, 32'h000000F4, 4'hF};
    v[2]  = '{LB,  2'd0, 32'h12F45678, 32'h00000078, 4'hF};
    v[3]  = '{LB,  2'd3, 32'h80112233, 32'hFFFFFF80, 4'hF};
    v[4]  = '{LH,  2'd2, 32'h80011234, 32'hFFFF8001, 4'hF};
    v[5]  = '{LHU, 2'd1, 32'h8001F234, 32'h0000F234, 4'hF};
    v[6]  = '{LH,  2'd0, 32'h00007FFF, 32'h00007FFF, 4'hF};
    v[7]  = '{LW,  2'd3, 32'hCAFEBABE, 32'hCAFEBABE, 4'hF};
    v[8]  = '{LWL, 2'd1, 32'hAABBCCDD, 32'hCCDD0000, 4'b1100};
    v[9]  = '{LWR, 2'd2, 32'hAABBCCDD, 32'h0000AABB, 4'b0011};
    v[10] = '{LWL, 2'd0, 32'hAABBCCDD, 32'hDD000000, 4'b1000};
    v[11] = '{LWR, 2'd3, 32'hAABBCCDD, 32'h000000AA, 4'b0001};
    v[12] = '{LWL, 2'd3, 32'hAABBCCDD, 32'hAABBCCDD, 4'hF};
    for (int i = 0; i < 13; i++) begin
      issue(mk(32'h300 + 4 * i, 5'd12, v[i].op, v[i].k, 32'h5A5A5A5A));
      data_sram_rdata = v[i].rdata; #1;
      n_cmp++; if (write_data !== v[i].data) begin n_err++; $display("FAIL load%0d_data got %h want %h", i, write_data, v[i].data); end
      n_cmp++; if (write_strobe !== v[i].strb) begin n_err++; $display("FAIL load%0d_strobe got %h want %h", i, write_strobe, v[i].strb); end
      n_cmp++; if (debug_wb_rf_wen !== v[i].strb) begin n_err++; $display("FAIL load%0d_dbg_wen got %h want %h", i, debug_wb_rf_wen, v[i].strb); end
      n_cmp++; if (wb_forward.partial !== (v[i].strb != 4'hF)) begin n_err++; $display("FAIL load%0d_partial got %b", i, wb_forward.partial); end
      if (v[i].strb == 4'hF) begin
        n_cmp++; if (wb_forward.data !== v[i].data) begin n_err++; $display("FAIL load%0d_fwd_data got %h want %h", i, wb_forward.data, v[i].data); end
      end
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    issue(mk(32'h200, 5'd5, NONE, 2'd0, 32'h55));
    mem_bundle = mk(32'h204, 5'd6, NONE, 2'd0, 32'h66); #1;
    n_cmp++; if (write_enabled !== 1'b1 || write_address !== 5'd5 || write_data !== 32'h55) begin n_err++; $display("FAIL b2b_first got wen=%b addr=%0d data=%h want 1/5/55", write_enabled, write_address, write_data); end
    n_cmp++; if (debug_wb_pc !== 32'h200) begin n_err++; $display("FAIL b2b_pc0 got %h want 200", debug_wb_pc); end
    n_cmp++; if (wb_allow_in !== 1'b1) begin n_err++; $display("FAIL b2b_allow0 got %b want 1", wb_allow_in); end
    @(posedge clock); #1; mem_valid = 1'b0; #1;
    n_cmp++; if (write_enabled !== 1'b1 || write_address !== 5'd6 || write_data !== 32'h66) begin n_err++; $display("FAIL b2b_second got wen=%b addr=%0d data=%h want 1/6/66", write_enabled, write_address, write_data); end
    n_cmp++; if (debug_wb_pc !== 32'h204) begin n_err++; $display("FAIL b2b_pc1 got %h want 204", debug_wb_pc); end
    n_cmp++; if (wb_allow_in !== 1'b1) begin n_err++; $display("FAIL b2b_allow1 got %b want 1", wb_allow_in); end
  endtask

  task automatic test_flush;
    issue(mk(32'h400, 5'd8, LW, 2'd0, 32'h0));
    data_sram_rdata = 32'h13572468;
    mem_bundle = mk(32'h404, 5'd9, NONE, 2'd0, 32'h99);
    flush = 1'b1; #1;
    n_cmp++; if (write_enabled !== 1'b0) begin n_err++; $display("FAIL flush_wen got %b want 0", write_enabled); end
    n_cmp++; if (debug_wb_rf_wen !== 4'b0) begin n_err++; $display("FAIL flush_dbg_wen got %h want 0", debug_wb_rf_wen); end
    n_cmp++; if (wb_forward.valid !== 1'b0) begin n_err++; $display("FAIL flush_fwd_valid got %b want 0", wb_forward.valid); end
    @(posedge clock); #1;
    flush = 1'b0; mem_valid = 1'b0; #1;
    n_cmp++; if (write_enabled !== 1'b0) begin n_err++; $display("FAIL flush_next_wen got %b want 0", write_enabled); end
  endtask

  task automatic test_idle;
    int writes;
    writes = 0;
    issue(mk(32'h500, 5'd4, NONE, 2'd0, 32'h4444));
    mem_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (write_enabled === 1'b1) writes++;
      @(posedge clock); #1;
    end
    n_cmp++; if (writes !== 1) begin n_err++; $display("FAIL idle_writes got %0d want 1", writes); end
    n_cmp++; if (write_enabled !== 1'b0) begin n_err++; $display("FAIL idle_wen got %b want 0", write_enabled); end
  endtask

  task automatic test_reset_mid;
    issue(mk(32'h600, 5'd10, LW, 2'd0, 32'h0));
    mem_valid = 1'b0; data_sram_rdata = 32'h0BADF00D; #1;
    n_cmp++; if (write_enabled !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_wen got %b want 1", write_enabled); end
    reset_n = 1'b0; #1;
    n_cmp++; if (write_enabled !== 1'b0) begin n_err++; $display("FAIL rstmid_wen got %b want 0", write_enabled); end
    n_cmp++; if (debug_wb_rf_wen !== 4'b0) begin n_err++; $display("FAIL rstmid_dbg_wen got %h want 0", debug_wb_rf_wen); end
    @(negedge clock); reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      n_cmp++; if (write_enabled !== 1'b0) begin n_err++; $display("FAIL rstmid_post%0d_wen got %b want 0", c, write_enabled); end
    end
    issue(mk(32'h604, 5'd11, NONE, 2'd0, 32'h1111));
    mem_valid = 1'b0; #1;
    n_cmp++; if (write_enabled !== 1'b1 || write_address !== 5'd11) begin n_err++; $display("FAIL rstmid_new got wen=%b addr=%0d want 1/11", write_enabled, write_address); end
  endtask

  task automatic test_dest_zero;
    issue(mk(32'h700, 5'd0, NONE, 2'd0, 32'h77));
    mem_valid = 1'b0; #1;
    n_cmp++; if (write_enabled !== 1'b1 || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'h77) begin n_err++; $display("FAIL dest0 got wen=%b wnum=%0d wdata=%h want 1/0/77", write_enabled, debug_wb_rf_wnum, debug_wb_rf_wdata); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_back_to_back;
    test_flush;
    test_idle;
    test_reset_mid;
    test_dest_zero;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
